// File: rtl/div_radix2_pkg.sv
// rtl/div_radix2_pkg.sv - shared state encodings and iteration constants for div_radix2
package div_radix2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DBZ  = 2'd1,
    ST_ON   = 2'd2,
    ST_END  = 2'd3
  } div_state_e;

  localparam int         DIV_ITER  = 32;
  localparam logic [4:0] LAST_ITER = 5'(DIV_ITER - 1);

endpackage

// File: rtl/div_radix2.sv
// rtl/div_radix2.sv - 32-bit radix-2 restoring divider, signed/unsigned, result {HI=rem, LO=quo}
module div_radix2
  import div_radix2_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic        annul,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  output logic [63:0] result,
  output logic        ready,
  output logic        stall_div
);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;
  logic [31:0] divisor_q, divisor_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] result_q, result_d;

  logic        start_ok;
  logic        op1_neg, op2_neg;
  logic [31:0] op1_abs, op2_abs;
  logic [64:0] work_sh, work_step;
  logic [32:0] trial;
  logic [31:0] quo_fix, rem_fix;
  logic        unused_bits;

  assign start_ok = div_start & ~annul;

  assign op1_neg = div_signed & opdata1[31];
  assign op2_neg = div_signed & opdata2[31];
  assign op1_abs = op1_neg ? (~opdata1 + 32'd1) : opdata1;
  assign op2_abs = op2_neg ? (~opdata2 + 32'd1) : opdata2;

  // One restoring step: shift, try a 33-bit subtract, keep it only if it did not borrow.
  assign work_sh   = {work_q[63:0], 1'b0};
  assign trial     = work_sh[64:32] - {1'b0, divisor_q};
  assign work_step = trial[32] ? work_sh : {trial, work_sh[31:1], 1'b1};

  assign quo_fix = neg_quo_q ? (~work_step[31:0] + 32'd1)  : work_step[31:0];
  assign rem_fix = neg_rem_q ? (~work_step[63:32] + 32'd1) : work_step[63:32];

  // Bit 64 stays zero: a restored remainder is always below the divisor.
  assign unused_bits = ^{work_q[64], work_step[64]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = (opdata2 == 32'd0) ? ST_DBZ : ST_ON;
        end
      end
      ST_DBZ:  state_d = annul ? ST_IDLE : ST_END;
      ST_ON: begin
        if (annul) begin
          state_d = ST_IDLE;
        end else if (cnt_q == LAST_ITER) begin
          state_d = ST_END;
        end
      end
      ST_END:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok && opdata2 != 32'd0) begin
          cnt_d     = 5'd0;
          work_d    = {33'd0, op1_abs};
          divisor_d = op2_abs;
          neg_quo_d = op1_neg ^ op2_neg;
          neg_rem_d = op1_neg;
        end
      end
      ST_DBZ: begin
        if (!annul) begin
          result_d = 64'd0;
        end
      end
      ST_ON: begin
        if (!annul) begin
          work_d = work_step;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == LAST_ITER) begin
            result_d = {rem_fix, quo_fix};
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 5'd0;
      work_q    <= 65'd0;
      divisor_q <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= 64'd0;
    end else begin
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    result    = result_q;
    ready     = (state_q == ST_END);
    stall_div = ((state_q == ST_IDLE) & start_ok) | (state_q == ST_ON) | (state_q == ST_DBZ);
  end

endmodule

// File: tb/tb_div_radix2.sv
// tb/tb_div_radix2.sv - randomized self-checking bench for div_radix2 against an arithmetic model
module tb_div_radix2;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_start;
  logic        div_signed;
  logic        annul;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        ready;
  logic        stall_div;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] last_res = 64'd0;

  always #5 clk = ~clk;

  div_radix2 dut (
    .clk       (clk),
    .rst       (rst),
    .div_start (div_start),
    .div_signed(div_signed),
    .annul     (annul),
    .opdata1   (opdata1),
    .opdata2   (opdata2),
    .result    (result),
    .ready     (ready),
    .stall_div (stall_div)
  );

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [31:0] q;
    logic [31:0] r;
    int sa;
    int sb;
    if (b == 32'd0) return 64'd0;
    if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      sa = a;
      sb = b;
      q = sa / sb;
      r = sa % sb;
    end
    return {r, q};
  endfunction

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn, input string tag);
    logic [63:0] exp;
    int lat;
    bit got;
    exp = model(a, b, sgn);
    lat = (b == 32'd0) ? 2 : 33;
    @(negedge clk);
    div_start = 1'b1; div_signed = sgn; opdata1 = a; opdata2 = b; annul = 1'b0;
    #1;
    vectors++;
    if (stall_div !== 1'b1) begin
      miscompares++;
      $display("FAIL %s stall_at_start: got %b want 1", tag, stall_div);
    end
    got = 1'b0;
    for (int n = 1; n <= 40 && !got; n++) begin
      @(negedge clk);
      opdata1 = $urandom; opdata2 = $urandom; div_signed = 1'($urandom);
      #1;
      if (ready === 1'b1) begin
        got = 1'b1;
        div_start = 1'b0;
        vectors++;
        if (n != lat) begin
          miscompares++;
          $display("FAIL %s latency: got %0d want %0d", tag, n, lat);
        end
        vectors++;
        if (result !== exp) begin
          miscompares++;
          $display("FAIL %s result a=%h b=%h s=%b: got %h want %h", tag, a, b, sgn, result, exp);
        end
        vectors++;
        if (stall_div !== 1'b0) begin
          miscompares++;
          $display("FAIL %s stall_in_end: got %b want 0", tag, stall_div);
        end
      end else begin
        vectors++;
        if (stall_div !== 1'b1) begin
          miscompares++;
          $display("FAIL %s stall_busy cycle %0d: got %b want 1", tag, n, stall_div);
        end
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      div_start = 1'b0;
      $display("FAIL %s timeout: ready not seen within 40 cycles, want %0d", tag, lat);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (ready !== 1'b0 || result !== exp) begin
      miscompares++;
      $display("FAIL %s after_end: ready=%b result=%h want ready=0 result=%h", tag, ready, result, exp);
    end
    last_res = exp;
  endtask

  task automatic test_reset();
    rst = 1'b1; div_start = 1'b0; div_signed = 1'b0; annul = 1'b0;
    opdata1 = 32'd0; opdata2 = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (result !== 64'd0 || ready !== 1'b0 || stall_div !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: result=%h ready=%b stall=%b want 0/0/0", result, ready, stall_div);
    end
    rst = 1'b0;
    last_res = 64'd0;
  endtask

  task automatic test_directed();
    run_div(32'd100, 32'd7, 1'b0, "udiv_100_7");
    vectors++;
    if (result !== 64'h0000_0002_0000_000E) begin
      miscompares++;
      $display("FAIL udiv_100_7_const: got %h want 000000020000000e", result);
    end
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "sdiv_m7_2");
    vectors++;
    if (result !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      miscompares++;
      $display("FAIL sdiv_m7_2_const: got %h want fffffffffffffffd", result);
    end
    run_div(32'd5, 32'd0, 1'b0, "udiv_by_zero");
    run_div(32'd5, 32'd0, 1'b1, "sdiv_by_zero");
    vectors++;
    if (result !== 64'd0) begin
      miscompares++;
      $display("FAIL dbz_const: got %h want 0", result);
    end
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "sdiv_min_m1");
    vectors++;
    if (result !== 64'h0000_0000_8000_0000) begin
      miscompares++;
      $display("FAIL sdiv_min_m1_const: got %h want 0000000080000000", result);
    end
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, "udiv_max_1");
    run_div(32'd7, 32'd100, 1'b0, "udiv_small");
    run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "udiv_max_max");
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, "sdiv_7_m2");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom_range(1, 15);
        1: b = 32'd0;
        2: b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      run_div(a, b, 1'($urandom), "random");
    end
  endtask

  task automatic test_annul();
    logic [63:0] prior;
    prior = last_res;
    @(negedge clk);
    div_start = 1'b1; annul = 1'b1; opdata1 = 32'd50; opdata2 = 32'd5; div_signed = 1'b0;
    #1;
    vectors++;
    if (stall_div !== 1'b0) begin
      miscompares++;
      $display("FAIL annul_idle_stall: got %b want 0", stall_div);
    end
    @(negedge clk);
    div_start = 1'b0; annul = 1'b0;
    #1;
    vectors++;
    if (stall_div !== 1'b0 || ready !== 1'b0) begin
      miscompares++;
      $display("FAIL annul_idle_nostart: stall=%b ready=%b want 0/0", stall_div, ready);
    end
    @(negedge clk);
    div_start = 1'b1; opdata1 = 32'd5; opdata2 = 32'd0;
    @(negedge clk);
    div_start = 1'b0; annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    #1;
    vectors++;
    if (ready !== 1'b0 || stall_div !== 1'b0 || result !== prior) begin
      miscompares++;
      $display("FAIL annul_dbz: ready=%b stall=%b result=%h want 0/0/%h", ready, stall_div, result, prior);
    end
    @(negedge clk);
    div_start = 1'b1; opdata1 = 32'd100; opdata2 = 32'd7; div_signed = 1'b0;
    repeat (9) @(negedge clk);
    @(negedge clk);
    div_start = 1'b0; annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    #1;
    vectors++;
    if (stall_div !== 1'b0 || ready !== 1'b0) begin
      miscompares++;
      $display("FAIL annul_on_t11: stall=%b ready=%b want 0/0", stall_div, ready);
    end
    for (int n = 0; n < 35; n++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (ready !== 1'b0 || stall_div !== 1'b0 || result !== prior) begin
        miscompares++;
        $display("FAIL annul_on_hold cycle %0d: ready=%b stall=%b result=%h want 0/0/%h", n, ready, stall_div, result, prior);
      end
    end
    run_div(32'd9, 32'd3, 1'b0, "after_annul_9_3");
    vectors++;
    if (result !== 64'h0000_0000_0000_0003) begin
      miscompares++;
      $display("FAIL after_annul_9_3_const: got %h want 0000000000000003", result);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    div_start = 1'b1; opdata1 = 32'd100; opdata2 = 32'd7; div_signed = 1'b0; annul = 1'b0;
    repeat (4) @(negedge clk);
    @(negedge clk);
    rst = 1'b1; div_start = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if (result !== 64'd0 || ready !== 1'b0 || stall_div !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: result=%h ready=%b stall=%b want 0/0/0", result, ready, stall_div);
    end
    rst = 1'b0;
    run_div(32'd100, 32'd7, 1'b0, "after_reset_100_7");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_annul();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_radix2.md
DIV_RADIX2 -- requirements
Module: div_radix2

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 div_start  input  1  request a division; the EX stage holds it high while the divide instruction stalls in EX.
REQ-005 div_signed  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with div_start.
REQ-006 annul  input  1  cancels the operation in flight; driven from the exception flush.
REQ-007 opdata1  input  32  dividend; sampled with div_start.
REQ-008 opdata2  input  32  divisor; sampled with div_start.
REQ-009 result  output  64  {remainder[63:32], quotient[31:0]}, which maps to {HI, LO}.
REQ-010 ready  output  1  result is valid in this cycle; one-cycle pulse.
REQ-011 stall_div  output  1  busy indication that feeds the stall_divE input of the hazard unit.

Function
REQ-012 The state machine SHALL have four states: IDLE, DBZ (divide by zero), ON and END.
REQ-013 IDLE transitions:
- div_start=1, annul=0, opdata2==0: go to DBZ.
- div_start=1, annul=0, opdata2!=0: go to ON, latch the operands and div_signed, and clear the 5-bit counter.
- Any other input combination: stay in IDLE.
REQ-014 DBZ SHALL go to END after one cycle and force result to 0.
REQ-015 ON SHALL retire one quotient bit per cycle using restoring shift-subtract on the 32-bit magnitudes.
- The partial-remainder subtraction is 33 bits wide.
- After the counter reaches 31 (32 iterations), the state goes to END.
REQ-016 END SHALL assert ready=1 for exactly one cycle, drive the final result, and then return to IDLE unconditionally.
REQ-017 Latency: for a start sampled in cycle T, ready SHALL rise in cycle T+33 (nonzero divisor) or T+2 (zero divisor).
REQ-018 stall_div SHALL equal (state==IDLE & div_start & ~annul) | state==ON | state==DBZ.
- It is combinational.
- It is low in END, so the pipeline advances in the same cycle that ready is high.
REQ-019 Signed mode operand handling:
- The operands are converted to absolute values at start.
- The quotient is negated when the operand signs differ.
- The remainder takes the sign of the dividend.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL produce quotient 0x80000000 and remainder 0; no trap is raised.
REQ-021 result SHALL hold its last value from END until the next END, including through annul.
REQ-022 annul=1 in DBZ or ON SHALL force IDLE on the next edge; ready and result are not updated.
REQ-023 annul=1 in END SHALL suppress nothing; the cycle completes normally.
REQ-024 Operand inputs SHALL be ignored outside the start cycle.
REQ-025 A div_start still high in END SHALL NOT restart the division; a new start is honoured only in IDLE.

Reset
REQ-026 rst=1 SHALL, on the next edge and from any state, set:
- state = IDLE
- counter = 0
- result = 0
- ready = 0
- internal operand and partial-remainder registers = 0
REQ-027 stall_div SHALL be 0 in the cycle after reset unless a fresh div_start arrives with annul=0.
REQ-028 rst SHALL take priority over annul and div_start.

Structure
REQ-029 The state encodings (2-bit) and DIV_ITER=32 SHALL be defined in the shared defines header that the datapath also includes.
REQ-030 The block SHALL be a single module with no sub-module.
- The absolute-value and negation logic stays inline as combinational assigns.
- The iteration datapath stays inline as one registered 65-bit working register: {remainder, dividend/quotient}.

Verification
REQ-031 Unsigned 100/7 started at T: stall_div=1 for cycles T..T+32, ready=1 only at T+33, result={0x00000002, 0x0000000E}.
REQ-032 Signed 0xFFFFFFF9 / 0x00000002 (-7/2): result={0xFFFFFFFF, 0xFFFFFFFD}, which is remainder -1 and quotient -3.
REQ-033 5/0, either mode: ready at T+2, result=0, stall_div high only for T..T+1.
REQ-034 Signed 0x80000000 / 0xFFFFFFFF: result={0x00000000, 0x80000000}, ready at T+33.
REQ-035 Start 100/7, then annul at T+10: state is IDLE at T+11, ready never pulses, stall_div=0 from T+11, result keeps its prior value; a following start of 9/3 gives {0, 3}.
REQ-036 rst asserted at T+5 of a division: at T+6 all outputs are 0 and the state is IDLE; a start at T+7 completes normally at T+40.
